logic_axi4_lite_ram_responder: RTL and testbench



---
 rtl/logic_axi4_lite_ram_responder.sv | 159 +++++++++++++++
 tb/tb_logic_axi4_lite_ram_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_axi4_lite_ram_responder.sv
// AXI4-Lite responder terminating reads and writes into a word-addressed register array.
// Define LOGIC_AXI4_LITE_RAM_RESPONDER_PROT_CHECK_EN to reject unprivileged (prot[0]=0) accesses.

package logic_pkg;
   typedef enum logic [1:0] {
      TARGET_GENERIC,
      TARGET_XILINX,
      TARGET_INTEL
   } target_t;
endpackage

package logic_axi4_lite_pkg;
   typedef struct packed {
      logic instruction;
      logic non_secure;
      logic privileged;
   } access_t;

   typedef enum logic [1:0] {
      RESPONSE_OKAY   = 2'b00,
      RESPONSE_EXOKAY = 2'b01,
      RESPONSE_SLVERR = 2'b10,
      RESPONSE_DECERR = 2'b11
   } response_t;
endpackage

module logic_axi4_lite_ram_responder
   import logic_axi4_lite_pkg::*;
#(
   parameter logic_pkg::target_t TARGET        = logic_pkg::TARGET_GENERIC,
   parameter int                 DATA_BYTES    = 4,
   parameter int                 ADDRESS_WIDTH = 8,
   parameter int                 WORDS         = 64
) (
   input  logic                         aclk,
   input  logic                         areset_n,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [ADDRESS_WIDTH-1:0]     awaddr,
   input  access_t                      awprot,
   input  logic                         wvalid,
   output logic                         wready,
   input  logic [DATA_BYTES*8-1:0]      wdata,
   input  logic [DATA_BYTES-1:0]        wstrb,
   output logic                         bvalid,
   input  logic                         bready,
   output response_t                    bresp,
   input  logic                         arvalid,
   output logic                         arready,
   input  logic [ADDRESS_WIDTH-1:0]     araddr,
   input  access_t                      arprot,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [DATA_BYTES*8-1:0]      rdata,
   output response_t                    rresp
);
   localparam int DATA_WIDTH  = DATA_BYTES * 8;
   localparam int OFFSET      = $clog2(DATA_BYTES);
   localparam int INDEX_WIDTH = (WORDS > 1) ? $clog2(WORDS) : 1;

   logic [DATA_WIDTH-1:0]    mem [WORDS];

   logic                     aw_full;
   logic                     w_full;
   logic [ADDRESS_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0]    w_data_q;
   logic [DATA_BYTES-1:0]    w_strb_q;
   logic                     commit;
   logic                     aw_hs;
   logic                     w_hs;
   logic                     ar_hs;
   logic                     aw_ok;
   logic                     ar_ok;
   logic                     unused_ok;

   function automatic logic [INDEX_WIDTH-1:0] word_index(input logic [ADDRESS_WIDTH-1:0] addr);
      return INDEX_WIDTH'(64'(addr) >> OFFSET);
   endfunction

   function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] addr);
      return (64'(addr) >> OFFSET) < 64'(WORDS);
   endfunction

   // A write retires once both halves are held and the B slot is free or draining.
   assign commit  = areset_n && aw_full && w_full && (!bvalid || bready);
   assign awready = areset_n && (!aw_full || commit);
   assign wready  = areset_n && (!w_full || commit);
   assign arready = areset_n && (!rvalid || rready);

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign ar_hs = arvalid && arready;

`ifdef LOGIC_AXI4_LITE_RAM_RESPONDER_PROT_CHECK_EN
   logic aw_priv_q;

   always_ff @(posedge aclk) begin
      if (aw_hs) aw_priv_q <= awprot.privileged;
   end

   assign aw_ok = in_range(aw_addr_q) && aw_priv_q;
   assign ar_ok = in_range(araddr) && arprot.privileged;
`else
   assign aw_ok = in_range(aw_addr_q);
   assign ar_ok = in_range(araddr);
`endif

   assign unused_ok = ^{TARGET, awprot, arprot};

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         bvalid  <= 1'b0;
         bresp   <= RESPONSE_OKAY;
         rvalid  <= 1'b0;
         rresp   <= RESPONSE_OKAY;
         rdata   <= '0;
      end else begin
         if (aw_hs)       aw_full <= 1'b1;
         else if (commit) aw_full <= 1'b0;

         if (w_hs)        w_full <= 1'b1;
         else if (commit) w_full <= 1'b0;

         if (commit) begin
            bvalid <= 1'b1;
            bresp  <= aw_ok ? RESPONSE_OKAY : RESPONSE_SLVERR;
         end else if (bready) begin
            bvalid <= 1'b0;
         end

         // The array is sampled before this edge's commit lands: same-index reads see old data.
         if (ar_hs) begin
            rvalid <= 1'b1;
            rresp  <= ar_ok ? RESPONSE_OKAY : RESPONSE_SLVERR;
            rdata  <= ar_ok ? mem[word_index(araddr)] : '0;
         end else if (rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   // NOTE: payload registers and the array are deliberately left without reset; the
   // full/valid flags qualify them, and this keeps the array mappable onto plain RAM.
   always_ff @(posedge aclk) begin
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
         w_data_q <= wdata;
         w_strb_q <= wstrb;
      end
      if (commit && aw_ok) begin
         for (int i = 0; i < DATA_BYTES; i++) begin
            if (w_strb_q[i]) mem[word_index(aw_addr_q)][8*i +: 8] <= w_data_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_logic_axi4_lite_ram_responder.sv
// Scoreboard bench for logic_axi4_lite_ram_responder: directed scenarios plus randomized traffic.
// Honours LOGIC_AXI4_LITE_RAM_RESPONDER_PROT_CHECK_EN in its reference model.

module tb_logic_axi4_lite_ram_responder;
   localparam int AW    = 10;
   localparam int WORDS = 64;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
`ifdef LOGIC_AXI4_LITE_RAM_RESPONDER_PROT_CHECK_EN
   localparam bit PROT_EN = 1'b1;
`else
   localparam bit PROT_EN = 1'b0;
`endif

   logic          aclk = 1'b0;
   logic          areset_n = 1'b0;
   logic          awvalid = 1'b0, awready;
   logic [AW-1:0] awaddr = '0;
   logic [2:0]    awprot = '0;
   logic          wvalid = 1'b0, wready;
   logic [31:0]   wdata = '0;
   logic [3:0]    wstrb = '0;
   logic          bvalid, bready = 1'b1;
   logic [1:0]    bresp;
   logic          arvalid = 1'b0, arready;
   logic [AW-1:0] araddr = '0;
   logic [2:0]    arprot = '0;
   logic          rvalid, rready = 1'b1;
   logic [31:0]   rdata;
   logic [1:0]    rresp;

   logic_axi4_lite_ram_responder #(
      .TARGET(logic_pkg::TARGET_GENERIC), .DATA_BYTES(4), .ADDRESS_WIDTH(AW), .WORDS(WORDS)
   ) dut (
      .aclk(aclk), .areset_n(areset_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   always #5 aclk = ~aclk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s", name);
   endtask

   // Reference model: plain word array plus in-order queues of accepted requests.
   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      bit          chk;
   } rexp_t;

   logic [31:0]   ref_mem [WORDS];
   bit            known   [WORDS];
   logic [AW-1:0] aw_q_addr [$];
   logic          aw_q_priv [$];
   logic [31:0]   w_q_data  [$];
   logic [3:0]    w_q_strb  [$];
   rexp_t         r_q       [$];

   function automatic bit access_ok(input logic [AW-1:0] addr, input logic priv);
      return (int'(addr) / 4 < WORDS) && (!PROT_EN || priv);
   endfunction

   initial begin : monitor
      logic          p_bvalid, p_bready, p_rvalid, p_rready;
      logic [1:0]    p_bresp, p_rresp;
      logic [31:0]   p_rdata;
      logic [AW-1:0] a;
      logic          pv;
      logic [31:0]   d;
      logic [3:0]    s;
      int            idx;
      bit            ok;
      rexp_t         e;
      p_bvalid = 1'b0; p_bready = 1'b0; p_rvalid = 1'b0; p_rready = 1'b0;
      p_bresp = '0; p_rresp = '0; p_rdata = '0;
      forever begin
         @(negedge aclk);
         if (!areset_n) begin
            aw_q_addr.delete(); aw_q_priv.delete(); w_q_data.delete(); w_q_strb.delete(); r_q.delete();
            p_bvalid = 1'b0; p_bready = 1'b0; p_rvalid = 1'b0; p_rready = 1'b0;
         end else begin
            if (bvalid && (!p_bvalid || p_bready)) begin
               if (aw_q_addr.size() == 0 || w_q_data.size() == 0) begin
                  fail_now("b_unexpected");
               end else begin
                  a = aw_q_addr.pop_front(); pv = aw_q_priv.pop_front();
                  d = w_q_data.pop_front();  s = w_q_strb.pop_front();
                  ok = access_ok(a, pv);
                  check("bresp", bresp, ok ? OKAY : SLVERR);
                  if (ok) begin
                     idx = int'(a) / 4;
                     for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                     known[idx] = known[idx] || (s == 4'hF);
                  end
               end
            end else if (bvalid && p_bvalid && !p_bready) begin
               check("bresp_hold", bresp, p_bresp);
            end

            if (rvalid && (!p_rvalid || p_rready)) begin
               if (r_q.size() == 0) begin
                  fail_now("r_unexpected");
               end else begin
                  e = r_q.pop_front();
                  check("rresp", rresp, e.resp);
                  if (e.chk) check("rdata", rdata, e.data);
               end
            end else if (rvalid && p_rvalid && !p_rready) begin
               check("rdata_hold", rdata, p_rdata);
            end

            if (awvalid && awready) begin aw_q_addr.push_back(awaddr); aw_q_priv.push_back(awprot[0]); end
            if (wvalid && wready) begin w_q_data.push_back(wdata); w_q_strb.push_back(wstrb); end
            if (arvalid && arready) begin
               idx = int'(araddr) / 4;
               if (access_ok(araddr, arprot[0])) begin
                  e.data = ref_mem[idx]; e.resp = OKAY; e.chk = known[idx];
               end else begin
                  e.data = '0; e.resp = SLVERR; e.chk = 1'b1;
               end
               r_q.push_back(e);
            end

            p_bvalid = bvalid; p_bready = bready; p_bresp = bresp;
            p_rvalid = rvalid; p_rready = rready; p_rresp = rresp; p_rdata = rdata;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge aclk); #1; end
   endtask

   task automatic send_aw(input logic [AW-1:0] a, input logic [2:0] p);
      bit fired = 1'b0;
      int n = 0;
      awaddr = a; awprot = p; awvalid = 1'b1;
      while (!fired && n < 100) begin
         @(negedge aclk); fired = awready; n++;
         @(posedge aclk); #1;
      end
      awvalid = 1'b0;
      if (!fired) fail_now("aw_timeout");
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      bit fired = 1'b0;
      int n = 0;
      wdata = d; wstrb = s; wvalid = 1'b1;
      while (!fired && n < 100) begin
         @(negedge aclk); fired = wready; n++;
         @(posedge aclk); #1;
      end
      wvalid = 1'b0;
      if (!fired) fail_now("w_timeout");
   endtask

   task automatic send_ar(input logic [AW-1:0] a, input logic [2:0] p);
      bit fired = 1'b0;
      int n = 0;
      araddr = a; arprot = p; arvalid = 1'b1;
      while (!fired && n < 100) begin
         @(negedge aclk); fired = arready; n++;
         @(posedge aclk); #1;
      end
      arvalid = 1'b0;
      if (!fired) fail_now("ar_timeout");
   endtask

   task automatic send_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [2:0] p);
      fork
         send_aw(a, p);
         send_w(d, s);
      join
   endtask

   task automatic write_check(input string name, input logic [AW-1:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [2:0] p, input logic [1:0] exp);
      send_write(a, d, s, p);
      @(negedge aclk); check({name, "_bvalid_early"}, bvalid, 1'b0);
      @(negedge aclk); check({name, "_bvalid"}, bvalid, 1'b1);
      check({name, "_bresp"}, bresp, exp);
      @(posedge aclk); #1;
   endtask

   task automatic read_check(input string name, input logic [AW-1:0] a, input logic [2:0] p,
                             input logic [31:0] exp_data, input logic [1:0] exp_resp);
      send_ar(a, p);
      @(negedge aclk);
      check({name, "_rvalid"}, rvalid, 1'b1);
      check({name, "_rdata"}, rdata, exp_data);
      check({name, "_rresp"}, rresp, exp_resp);
      @(posedge aclk); #1;
   endtask

   task automatic do_reset();
      areset_n = 1'b0;
      idle(2);
      @(negedge aclk);
      check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
      check("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
      check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      @(posedge aclk); #1;
      areset_n = 1'b1;
      @(negedge aclk);
      check("post_rst_ready", {29'd0, awready, wready, arready}, 32'd7);
      @(posedge aclk); #1;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 4) != 0) return AW'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(0, 3));
      return AW'($urandom);
   endfunction

   bit rand_done = 1'b0;

   initial begin
      logic [31:0] old_val;
      do_reset();

      for (int i = 0; i < WORDS; i++) send_write(AW'(i * 4), $urandom, 4'hF, 3'b001);
      idle(3);

      write_check("wr04", 10'h004, 32'hDEADBEEF, 4'hF, 3'b001, OKAY);
      read_check("rd04", 10'h004, 3'b001, 32'hDEADBEEF, OKAY);

      fork
         send_w(32'h11223344, 4'hF);
         begin idle(3); send_aw(10'h008, 3'b001); end
      join
      idle(2);
      write_check("wr08_partial", 10'h008, 32'h0000AAAA, 4'h3, 3'b001, OKAY);
      read_check("rd08", 10'h008, 3'b001, 32'h1122AAAA, OKAY);

      write_check("wr100", 10'h100, 32'h55555555, 4'hF, 3'b001, SLVERR);
      read_check("rd100", 10'h100, 3'b001, 32'h0, SLVERR);
      read_check("rd3fc", 10'h3FC, 3'b001, 32'h0, SLVERR);
      read_check("rd00", 10'h000, 3'b001, ref_mem[0], OKAY);

      bready = 1'b0;
      fork
         begin
            send_write(10'h020, 32'hA5A5A5A5, 4'hF, 3'b001);
            send_write(10'h024, 32'h5A5A5A5A, 4'hF, 3'b001);
         end
         begin
            repeat (5) @(negedge aclk);
            check("bp_awready", awready, 1'b0);
            check("bp_wready", wready, 1'b0);
            check("bp_bvalid", bvalid, 1'b1);
            @(posedge aclk); #1;
            bready = 1'b1;
         end
      join
      idle(3);
      check("bp_release_ready", {30'd0, awready, wready}, 32'd3);

      old_val = ref_mem[3];
      fork
         send_write(10'h00C, ~old_val, 4'hF, 3'b001);
         begin idle(1); send_ar(10'h00C, 3'b001); end
      join
      @(negedge aclk);
      check("same_cycle_old", rdata, old_val);
      @(posedge aclk); #1;
      idle(1);
      read_check("same_cycle_new", 10'h00C, 3'b001, ~old_val, OKAY);

      old_val = ref_mem[4];
      write_check("prot0", 10'h010, ~old_val, 4'hF, 3'b000, PROT_EN ? SLVERR : OKAY);
      read_check("prot0_rd", 10'h010, 3'b001, PROT_EN ? old_val : ~old_val, OKAY);
      write_check("prot1", 10'h010, 32'h0BADF00D, 4'hF, 3'b001, OKAY);
      read_check("prot1_rd", 10'h010, 3'b001, 32'h0BADF00D, OKAY);
      read_check("prot_rd_unpriv", 10'h010, 3'b000, PROT_EN ? 32'h0 : 32'h0BADF00D,
                 PROT_EN ? SLVERR : OKAY);

      old_val = ref_mem[6];
      bready = 1'b0;
      send_write(10'h014, 32'h13572468, 4'hF, 3'b001);
      send_write(10'h018, ~old_val, 4'hF, 3'b001);
      idle(2);
      do_reset();
      bready = 1'b1;
      read_check("rst_drop", 10'h018, 3'b001, old_val, OKAY);

      fork
         begin
            fork
               for (int i = 0; i < 300; i++) begin
                  idle($urandom_range(0, 2));
                  send_aw(rand_addr(), 3'($urandom));
               end
               for (int i = 0; i < 300; i++) begin
                  idle($urandom_range(0, 2));
                  send_w($urandom, 4'($urandom));
               end
               for (int i = 0; i < 300; i++) begin
                  idle($urandom_range(0, 2));
                  send_ar(rand_addr(), 3'($urandom));
               end
            join
            rand_done = 1'b1;
         end
         while (!rand_done) begin
            bready = ($urandom_range(0, 3) != 0);
            rready = ($urandom_range(0, 3) != 0);
            @(posedge aclk); #1;
         end
      join

      bready = 1'b1;
      rready = 1'b1;
      idle(10);
      check("drained", aw_q_addr.size() + w_q_data.size() + r_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
